// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Multi-cycle control FSM for an RV64 subset (add/sub/and/or,
//               ld, sd, beq). Sequences a shared memory port, register file,
//               ALU and PC. Includes a memory-wait timeout, sticky trap flags
//               and a retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 255,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic [6:0]             opCode,
  input  logic                   zero,
  input  logic                   memReady,
  output logic                   memRead,
  output logic                   memWrite,
  output logic                   iOrD,
  output logic                   irWrite,
  output logic                   pcWrite,
  output logic                   pcSrc,
  output logic                   regWrite,
  output logic                   memToReg,
  output logic                   aluSrcA,
  output logic [1:0]             aluSrcB,
  output logic [1:0]             aluOp,
  output logic                   illegalOp,
  output logic                   busError,
  output logic [3:0]             state,
  output logic [COUNT_WIDTH-1:0] instrCount
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] C_WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  localparam logic [6:0] C_OP_R   = 7'b0110011;
  localparam logic [6:0] C_OP_LD  = 7'b0000011;
  localparam logic [6:0] C_OP_SD  = 7'b0100011;
  localparam logic [6:0] C_OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_WB_MEM   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_BRANCH   = 4'd8,
    S_TRAP     = 4'd9
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [WAIT_W-1:0]      r_wait;
  logic [12:0]            r_ctl;
  logic                   r_illegal;
  logic                   r_bus;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   w_waiting;
  logic                   w_expired;
  logic                   w_retire;
  logic                   w_illegal;

  // Moore control word per state, bit order:
  // memRead memWrite iOrD irWrite pcWrite pcSrc regWrite memToReg aluSrcA aluSrcB[1:0] aluOp[1:0]
  // irWrite/pcWrite here are enables that are further qualified by memReady/zero.
  function automatic logic [12:0] ctl_for(input state_t s);
    case (s)
      S_FETCH:    ctl_for = 13'b1_0_0_1_1_0_0_0_0_01_00;
      S_DECODE:   ctl_for = 13'b0_0_0_0_0_0_0_0_0_10_00;
      S_MEM_ADDR: ctl_for = 13'b0_0_0_0_0_0_0_0_1_10_00;
      S_MEM_RD:   ctl_for = 13'b1_0_1_0_0_0_0_0_0_00_00;
      S_WB_MEM:   ctl_for = 13'b0_0_0_0_0_0_1_1_0_00_00;
      S_MEM_WR:   ctl_for = 13'b0_1_1_0_0_0_0_0_0_00_00;
      S_EXEC_R:   ctl_for = 13'b0_0_0_0_0_0_0_0_1_00_10;
      S_WB_ALU:   ctl_for = 13'b0_0_0_0_0_0_1_0_0_00_00;
      S_BRANCH:   ctl_for = 13'b0_0_0_0_1_1_0_0_1_00_01;
      default:    ctl_for = 13'b0;
    endcase
  endfunction

  // Only the three memory states wait on memReady; elsewhere it is ignored.
  assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  // A late ack on the expiry cycle still wins, so expiry requires memReady low.
  assign w_expired = w_waiting && !memReady && (r_wait == C_WAIT_MAX);

  // Next-state decode plus retire/illegal event strobes.
  always_comb begin
    w_next    = r_state;
    w_retire  = 1'b0;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (memReady)       w_next = S_DECODE;
        else if (w_expired) w_next = S_TRAP;
      end
      S_DECODE: begin
        case (opCode)
          C_OP_R:           w_next = S_EXEC_R;
          C_OP_LD, C_OP_SD: w_next = S_MEM_ADDR;
          C_OP_BEQ:         w_next = S_BRANCH;
          default: begin
            w_next    = S_TRAP;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: w_next = (opCode == C_OP_SD) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (memReady)       w_next = S_WB_MEM;
        else if (w_expired) w_next = S_TRAP;
      end
      S_WB_MEM: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_MEM_WR: begin
        if (memReady) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end else if (w_expired) begin
          w_next = S_TRAP;
        end
      end
      S_EXEC_R: w_next = S_WB_ALU;
      S_WB_ALU: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_BRANCH: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      default: w_next = S_TRAP;
    endcase
  end

  // State, registered control word, wait counter, sticky flags and retire counter.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state   <= S_FETCH;
      r_ctl     <= ctl_for(S_FETCH);
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_bus     <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state <= w_next;
      r_ctl   <= ctl_for(w_next);
      // Any state change restarts the wait count; staying in a memory state means still waiting.
      if (w_next != r_state) r_wait <= '0;
      else if (w_waiting)    r_wait <= r_wait + 1'b1;
      if (w_expired) r_bus     <= 1'b1;
      if (w_illegal) r_illegal <= 1'b1;
      if (w_retire)  r_count   <= r_count + 1'b1;
    end
  end

  assign memRead    = r_ctl[12];
  assign memWrite   = r_ctl[11];
  assign iOrD       = r_ctl[10];
  assign irWrite    = r_ctl[9] & memReady;
  // pcWrite is enabled only in FETCH (ack-qualified) and BRANCH (zero-qualified).
  assign pcWrite    = r_ctl[8] & ((r_state == S_FETCH) ? memReady : zero);
  assign pcSrc      = r_ctl[7];
  assign regWrite   = r_ctl[6];
  assign memToReg   = r_ctl[5];
  assign aluSrcA    = r_ctl[4];
  assign aluSrcB    = r_ctl[3:2];
  assign aluOp      = r_ctl[1:0];
  assign illegalOp  = r_illegal;
  assign busError   = r_bus;
  assign state      = r_state;
  assign instrCount = r_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Scoreboard bench for multicycle_controller. Stimulus pushes
//               the expected per-cycle output vector; a monitor pops and
//               compares it on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [6:0]  opCode = 7'd0;
  logic        zero = 1'b0;
  logic        memReady = 1'b0;
  logic        memRead, memWrite, iOrD, irWrite, pcWrite, pcSrc;
  logic        regWrite, memToReg, aluSrcA;
  logic [1:0]  aluSrcB, aluOp;
  logic        illegalOp, busError;
  logic [3:0]  state;
  logic [31:0] instrCount;

  // Control word: memRead memWrite iOrD irWrite pcWrite pcSrc regWrite memToReg aluSrcA aluSrcB aluOp
  localparam logic [12:0] E_FETCH_W = 13'b1_0_0_0_0_0_0_0_0_01_00;
  localparam logic [12:0] E_FETCH_A = 13'b1_0_0_1_1_0_0_0_0_01_00;
  localparam logic [12:0] E_DEC     = 13'b0_0_0_0_0_0_0_0_0_10_00;
  localparam logic [12:0] E_MADDR   = 13'b0_0_0_0_0_0_0_0_1_10_00;
  localparam logic [12:0] E_MRD     = 13'b1_0_1_0_0_0_0_0_0_00_00;
  localparam logic [12:0] E_WBM     = 13'b0_0_0_0_0_0_1_1_0_00_00;
  localparam logic [12:0] E_MWR     = 13'b0_1_1_0_0_0_0_0_0_00_00;
  localparam logic [12:0] E_EXR     = 13'b0_0_0_0_0_0_0_0_1_00_10;
  localparam logic [12:0] E_WBA     = 13'b0_0_0_0_0_0_1_0_0_00_00;
  localparam logic [12:0] E_BR1     = 13'b0_0_0_0_1_1_0_0_1_00_01;
  localparam logic [12:0] E_BR0     = 13'b0_0_0_0_0_1_0_0_1_00_01;
  localparam logic [12:0] E_NONE    = 13'b0;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b0010011;

  logic [26:0] expq[$];
  int total = 0;
  int bad = 0;

  multicycle_controller #(.MEM_TIMEOUT(255), .COUNT_WIDTH(32)) dut (
    .clk(clk), .resetN(resetN), .opCode(opCode), .zero(zero), .memReady(memReady),
    .memRead(memRead), .memWrite(memWrite), .iOrD(iOrD), .irWrite(irWrite),
    .pcWrite(pcWrite), .pcSrc(pcSrc), .regWrite(regWrite), .memToReg(memToReg),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp), .illegalOp(illegalOp),
    .busError(busError), .state(state), .instrCount(instrCount)
  );

  always #5 clk = ~clk;

  function automatic logic [26:0] observe();
    return {state, memRead, memWrite, iOrD, irWrite, pcWrite, pcSrc, regWrite,
            memToReg, aluSrcA, aluSrcB, aluOp, illegalOp, busError, instrCount[7:0]};
  endfunction

  // Monitor: compare the DUT against the oldest pending expectation each falling edge.
  always @(negedge clk) begin
    logic [26:0] e;
    logic [26:0] a;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a = observe();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle t=%0t exp_state=%0d got=%h want=%h", $time, e[26:23], a, e);
      end
    end
  end

  task automatic step(input logic [3:0] st, input logic [12:0] ctl, input logic rdy,
                      input logic z, input logic ill, input logic bus, input logic [7:0] cnt);
    memReady = rdy;
    zero     = z;
    expq.push_back({st, ctl, ill, bus, cnt});
    @(posedge clk);
    #1;
  endtask

  task automatic direct_check(input string name, input logic [26:0] want);
    logic [26:0] got;
    got = observe();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  initial begin
    logic hit;
    // Reset state while resetN is held low
    resetN = 1'b0;
    @(posedge clk);
    #1;
    step(4'd0, E_FETCH_W, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    resetN = 1'b1;

    // add: 0,1,6,7 then retire
    opCode = OP_R;
    step(4'd0, E_FETCH_A, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'd1, E_DEC,     1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'd6, E_EXR,     1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'd7, E_WBA,     1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // ld with memReady three cycles late in MEM_RD: 8 cycles total
    opCode = OP_LD;
    step(4'd0, E_FETCH_A, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    step(4'd1, E_DEC,     1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    step(4'd2, E_MADDR,   1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    for (int i = 0; i < 3; i++) step(4'd3, E_MRD, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    step(4'd3, E_MRD,     1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    step(4'd4, E_WBM,     1'b0, 1'b0, 1'b0, 1'b0, 8'd1);

    // beq taken then not taken
    opCode = OP_BEQ;
    step(4'd0, E_FETCH_A, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    step(4'd1, E_DEC,     1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    step(4'd8, E_BR1,     1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
    step(4'd0, E_FETCH_A, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
    step(4'd1, E_DEC,     1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
    step(4'd8, E_BR0,     1'b0, 1'b0, 1'b0, 1'b0, 8'd3);

    // sd acknowledged immediately: 4 cycles
    opCode = OP_SD;
    step(4'd0, E_FETCH_A, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4);
    step(4'd1, E_DEC,     1'b0, 1'b0, 1'b0, 1'b0, 8'd4);
    step(4'd2, E_MADDR,   1'b0, 1'b0, 1'b0, 1'b0, 8'd4);
    step(4'd5, E_MWR,     1'b1, 1'b0, 1'b0, 1'b0, 8'd4);

    // Unsupported opcode: trap, sticky illegalOp, no enables, count held; memReady ignored
    opCode = OP_BAD;
    step(4'd0, E_FETCH_A, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
    step(4'd1, E_DEC,     1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
    for (int i = 0; i < 20; i++) step(4'd9, E_NONE, 1'b1, 1'b1, 1'b1, 1'b0, 8'd5);

    // Reset clears the flags and the counter
    resetN = 1'b0;
    step(4'd0, E_FETCH_W, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    resetN = 1'b1;

    // sd with memReady never asserted: bus error and trap
    opCode = OP_SD;
    step(4'd0, E_FETCH_A, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'd1, E_DEC,     1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'd2, E_MADDR,   1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 255; i++) step(4'd5, E_MWR, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    memReady = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (state == 4'd9) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL timeout_trap state=%0d busError=%0d want state=9 within bound", state, busError);
    end
    step(4'd9, E_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    step(4'd9, E_NONE, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);

    // Reset out of TRAP, then reset asserted in the middle of a store
    resetN = 1'b0;
    step(4'd0, E_FETCH_W, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    resetN = 1'b1;
    step(4'd0, E_FETCH_A, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'd1, E_DEC,     1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'd2, E_MADDR,   1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'd5, E_MWR,     1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    #2;
    resetN = 1'b0;
    #1;
    direct_check("async_reset_mid_store", {4'd0, E_FETCH_W, 1'b0, 1'b0, 8'd0});
    @(posedge clk);
    #1;
    resetN = 1'b1;

    // add after reset retires from a zero count
    opCode = OP_R;
    step(4'd0, E_FETCH_A, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'd1, E_DEC,     1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'd6, E_EXR,     1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'd7, E_WBA,     1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'd0, E_FETCH_W, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);

    if (expq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain pending=%0d want=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
